// File: rtl/pc_pkg.sv
// Shared encodings and types for the fetch PC / branch prediction slice.
// Widths that depend on module parameters stay in the modules; this holds fixed-width items.
package pc_pkg;

  localparam int PC_XLEN = 32;

  localparam logic [2:0] BEQ  = 3'b000;
  localparam logic [2:0] BNE  = 3'b001;
  localparam logic [2:0] BLT  = 3'b100;
  localparam logic [2:0] BGE  = 3'b101;
  localparam logic [2:0] BLTU = 3'b110;
  localparam logic [2:0] BGEU = 3'b111;

  localparam logic [1:0] SNT = 2'd0;
  localparam logic [1:0] WNT = 2'd1;
  localparam logic [1:0] WT  = 2'd2;
  localparam logic [1:0] ST  = 2'd3;

  // Reset-able part of a BTB entry; tag and target live in parameter-width arrays.
  typedef struct packed {
    logic       valid;
    logic [1:0] cnt;
  } btb_entry_t;

  function automatic logic [1:0] cnt_next(input logic [1:0] c, input logic taken);
    if (taken) return (c == ST)  ? ST  : c + 2'd1;
    else       return (c == SNT) ? SNT : c - 2'd1;
  endfunction

endpackage

// File: rtl/BranchUnit.sv
// Branch condition from ALU flags of A-B (carry set means no unsigned borrow, i.e. A >= B).
// Purely combinational; unknown funct3 codes evaluate as not taken.
module BranchUnit
  import pc_pkg::*;
(
  input  logic [2:0] i_BranchType,
  input  logic       i_AluASign,
  input  logic       i_AluBSign,
  input  logic       i_AluCarry,
  input  logic       i_AluResZero,
  input  logic       i_AluResNeg,
  output logic       o_CondTrue
);

  logic w_Lt;
  // With differing signs the subtraction can overflow, so the sign of A decides.
  assign w_Lt = (i_AluASign != i_AluBSign) ? i_AluASign : i_AluResNeg;

  always_comb begin
    o_CondTrue = 1'b0;
    case (i_BranchType)
      BEQ:     o_CondTrue = i_AluResZero;
      BNE:     o_CondTrue = !i_AluResZero;
      BLT:     o_CondTrue = w_Lt;
      BGE:     o_CondTrue = !w_Lt;
      BLTU:    o_CondTrue = !i_AluCarry;
      BGEU:    o_CondTrue = i_AluCarry;
      default: o_CondTrue = 1'b0;
    endcase
  end

endmodule

// File: rtl/pc_btb.sv
// Direct-mapped BTB with 2-bit counters: combinational lookup, one training write per clock.
// Lookup sees pre-write contents; a write becomes visible on the next cycle.
module pc_btb
  import pc_pkg::*;
#(
  parameter int XLEN        = PC_XLEN,
  parameter int BTB_ENTRIES = 16
) (
  input  logic            i_Clk,
  input  logic            i_Rst,
  input  logic [XLEN-1:0] i_LookupPc,
  output logic            o_PredTaken,
  output logic [XLEN-1:0] o_PredTarget,
  input  logic            i_WrEn,
  input  logic [XLEN-1:2] i_WrPc,
  input  logic            i_WrTaken,
  input  logic [XLEN-1:0] i_WrTarget
);

  localparam int IDX_W = $clog2(BTB_ENTRIES);
  localparam int TAG_W = XLEN - IDX_W - 2;

  btb_entry_t        r_State  [BTB_ENTRIES];
  logic [TAG_W-1:0]  r_Tag    [BTB_ENTRIES];
  logic [XLEN-1:0]   r_Target [BTB_ENTRIES];

  logic [IDX_W-1:0] w_LkIdx, w_WrIdx;
  logic [TAG_W-1:0] w_LkTag, w_WrTag;
  logic             w_LkHit, w_WrHit, w_Alloc, w_Upd;

  assign w_LkIdx = i_LookupPc[IDX_W+1:2];
  assign w_LkTag = i_LookupPc[XLEN-1:IDX_W+2];
  assign w_LkHit = r_State[w_LkIdx].valid && (r_Tag[w_LkIdx] == w_LkTag);

  assign o_PredTaken  = w_LkHit && r_State[w_LkIdx].cnt[1];
  assign o_PredTarget = w_LkHit ? r_Target[w_LkIdx] : i_LookupPc + XLEN'(4);

  assign w_WrIdx = i_WrPc[IDX_W+1:2];
  assign w_WrTag = i_WrPc[XLEN-1:IDX_W+2];
  assign w_WrHit = r_State[w_WrIdx].valid && (r_Tag[w_WrIdx] == w_WrTag);
  // Only taken outcomes allocate; a taken miss evicts whatever shares the index.
  assign w_Alloc = i_WrEn && !w_WrHit && i_WrTaken;
  assign w_Upd   = i_WrEn && w_WrHit;

  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      for (int i = 0; i < BTB_ENTRIES; i++) begin
        r_State[i] <= '{valid: 1'b0, cnt: WNT};
      end
    end else if (w_Alloc) begin
      r_State[w_WrIdx] <= '{valid: 1'b1, cnt: WT};
    end else if (w_Upd) begin
      r_State[w_WrIdx].cnt <= cnt_next(r_State[w_WrIdx].cnt, i_WrTaken);
    end
  end

  always_ff @(posedge i_Clk) begin
    if (w_Alloc || (w_Upd && i_WrTaken)) begin
      r_Tag[w_WrIdx]    <= w_WrTag;
      r_Target[w_WrIdx] <= i_WrTarget;
    end
  end

endmodule

// File: rtl/pc_predict.sv
// Fetch PC register with BTB prediction, M-stage mispredict detection and trap/mret redirect.
// o_Pc is registered (redirect lands one clock later); o_Redirect/o_TakeBranch are combinational.
module pc_predict
  import pc_pkg::*;
#(
  parameter int              XLEN        = PC_XLEN,
  parameter logic [XLEN-1:0] RESET_VEC   = '0,
  parameter int              BTB_ENTRIES = 16
) (
  input  logic            i_Clk,
  input  logic            i_Rst,
  input  logic            i_PcEn,
  input  logic            i_Trap,
  input  logic [XLEN-1:0] i_TrapVec,
  input  logic            i_Mret,
  input  logic [XLEN-1:0] i_Epc,
  input  logic            i_Valid_M,
  input  logic            i_IsJump_M,
  input  logic            i_IsBranch_M,
  input  logic [2:0]      i_BranchType_M,
  input  logic            i_AluASign_M,
  input  logic            i_AluBSign_M,
  input  logic            i_AluCarry_M,
  input  logic            i_AluResZero_M,
  input  logic            i_AluResNeg_M,
  input  logic            i_BranchAdderBSel_M,
  input  logic [XLEN-1:0] i_Imm_M,
  input  logic [XLEN-1:0] i_PC_M,
  input  logic [XLEN-1:0] i_RS1_M,
  input  logic            i_PredTaken_M,
  input  logic [XLEN-1:0] i_PredTarget_M,
  output logic [XLEN-1:0] o_Pc,
  output logic            o_PredTaken,
  output logic [XLEN-1:0] o_PredTarget,
  output logic            o_TakeBranch,
  output logic            o_Redirect
);

  logic [XLEN-1:0] r_Pc;
  logic [XLEN-1:0] w_NextPc, w_Target, w_PcM4, w_Correct;
  logic            w_CondTrue, w_Taken, w_CtrlM, w_Mispredict, w_BtbWe;

  BranchUnit u_branch_unit (
    .i_BranchType (i_BranchType_M),
    .i_AluASign   (i_AluASign_M),
    .i_AluBSign   (i_AluBSign_M),
    .i_AluCarry   (i_AluCarry_M),
    .i_AluResZero (i_AluResZero_M),
    .i_AluResNeg  (i_AluResNeg_M),
    .o_CondTrue   (w_CondTrue)
  );

  assign w_CtrlM  = i_Valid_M && (i_IsBranch_M || i_IsJump_M);
  assign w_Taken  = i_IsJump_M || (i_IsBranch_M && w_CondTrue);
  assign w_Target = i_Imm_M + (i_BranchAdderBSel_M ? i_RS1_M : i_PC_M);
  assign w_PcM4   = i_PC_M + XLEN'(4);

  // A valid non-control instruction that was predicted taken must fall through.
  assign w_Mispredict = w_CtrlM
                      ? ((w_Taken != i_PredTaken_M) || (w_Taken && (w_Target != i_PredTarget_M)))
                      : (i_Valid_M && i_PredTaken_M);
  assign w_Correct    = (w_CtrlM && w_Taken) ? w_Target : w_PcM4;

  assign o_TakeBranch = w_CtrlM && w_Taken;
  assign o_Redirect   = i_Trap || i_Mret || w_Mispredict;
  assign w_BtbWe      = i_PcEn && w_CtrlM && !i_Trap;

  pc_btb #(
    .XLEN        (XLEN),
    .BTB_ENTRIES (BTB_ENTRIES)
  ) u_btb (
    .i_Clk        (i_Clk),
    .i_Rst        (i_Rst),
    .i_LookupPc   (r_Pc),
    .o_PredTaken  (o_PredTaken),
    .o_PredTarget (o_PredTarget),
    .i_WrEn       (w_BtbWe),
    .i_WrPc       (i_PC_M[XLEN-1:2]),
    .i_WrTaken    (w_Taken),
    .i_WrTarget   (w_Target)
  );

  // Trap and mret bypass the stall; everything else waits for i_PcEn.
  always_comb begin
    w_NextPc = r_Pc;
    if (i_Trap) begin
      w_NextPc = i_TrapVec;
    end else if (i_Mret) begin
      w_NextPc = i_Epc;
    end else if (i_PcEn) begin
      if (w_Mispredict)     w_NextPc = w_Correct;
      else if (o_PredTaken) w_NextPc = o_PredTarget;
      else                  w_NextPc = r_Pc + XLEN'(4);
    end
  end

  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) r_Pc <= RESET_VEC;
    else       r_Pc <= w_NextPc;
  end

  assign o_Pc = r_Pc;

endmodule

// File: tb/tb_pc_predict.sv
// Directed scenarios for pc_predict; each cycle's expectations go to a queue checked at negedge.
module tb_pc_predict;
  import pc_pkg::*;

  logic        i_Clk = 1'b0;
  logic        i_Rst, i_PcEn, i_Trap, i_Mret;
  logic [31:0] i_TrapVec, i_Epc;
  logic        i_Valid_M, i_IsJump_M, i_IsBranch_M;
  logic [2:0]  i_BranchType_M;
  logic        i_AluASign_M, i_AluBSign_M, i_AluCarry_M, i_AluResZero_M, i_AluResNeg_M;
  logic        i_BranchAdderBSel_M;
  logic [31:0] i_Imm_M, i_PC_M, i_RS1_M;
  logic        i_PredTaken_M;
  logic [31:0] i_PredTarget_M;
  logic [31:0] o_Pc, o_PredTarget;
  logic        o_PredTaken, o_TakeBranch, o_Redirect;

  pc_predict #(.XLEN(32), .RESET_VEC(32'h100), .BTB_ENTRIES(16)) dut (
    .i_Clk(i_Clk), .i_Rst(i_Rst), .i_PcEn(i_PcEn), .i_Trap(i_Trap), .i_TrapVec(i_TrapVec),
    .i_Mret(i_Mret), .i_Epc(i_Epc), .i_Valid_M(i_Valid_M), .i_IsJump_M(i_IsJump_M),
    .i_IsBranch_M(i_IsBranch_M), .i_BranchType_M(i_BranchType_M),
    .i_AluASign_M(i_AluASign_M), .i_AluBSign_M(i_AluBSign_M), .i_AluCarry_M(i_AluCarry_M),
    .i_AluResZero_M(i_AluResZero_M), .i_AluResNeg_M(i_AluResNeg_M),
    .i_BranchAdderBSel_M(i_BranchAdderBSel_M), .i_Imm_M(i_Imm_M), .i_PC_M(i_PC_M),
    .i_RS1_M(i_RS1_M), .i_PredTaken_M(i_PredTaken_M), .i_PredTarget_M(i_PredTarget_M),
    .o_Pc(o_Pc), .o_PredTaken(o_PredTaken), .o_PredTarget(o_PredTarget),
    .o_TakeBranch(o_TakeBranch), .o_Redirect(o_Redirect)
  );

  always #5 i_Clk = ~i_Clk;

  // kind 0: a=pc; kind 1: a=pred taken, b=pred target; kind 2: a=redirect, b=take branch
  typedef struct {
    string       nm;
    int          kind;
    logic [31:0] a;
    logic [31:0] b;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  always @(negedge i_Clk) begin
    while (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      case (e.kind)
        0: chk({e.nm, ".pc"}, o_Pc, e.a);
        1: begin
          chk({e.nm, ".pred_taken"}, {31'd0, o_PredTaken}, e.a);
          chk({e.nm, ".pred_target"}, o_PredTarget, e.b);
        end
        default: begin
          chk({e.nm, ".redirect"}, {31'd0, o_Redirect}, e.a);
          chk({e.nm, ".take_branch"}, {31'd0, o_TakeBranch}, e.b);
        end
      endcase
    end
  end

  task automatic exp_pc(input string nm, input logic [31:0] pc);
    q.push_back('{nm: nm, kind: 0, a: pc, b: 32'd0});
  endtask
  task automatic exp_pred(input string nm, input logic pt, input logic [31:0] tgt);
    q.push_back('{nm: nm, kind: 1, a: {31'd0, pt}, b: tgt});
  endtask
  task automatic exp_rd(input string nm, input logic rd, input logic tb);
    q.push_back('{nm: nm, kind: 2, a: {31'd0, rd}, b: {31'd0, tb}});
  endtask

  task automatic tick();
    @(posedge i_Clk);
    #1;
  endtask

  task automatic m_clear();
    i_Valid_M = 0; i_IsJump_M = 0; i_IsBranch_M = 0; i_BranchType_M = 3'b000;
    i_AluASign_M = 0; i_AluBSign_M = 0; i_AluCarry_M = 0; i_AluResZero_M = 0; i_AluResNeg_M = 0;
    i_BranchAdderBSel_M = 0; i_Imm_M = 0; i_PC_M = 0; i_RS1_M = 0;
    i_PredTaken_M = 0; i_PredTarget_M = 0;
  endtask

  task automatic m_set(input logic br, input logic jmp, input logic sel, input logic [2:0] ty,
                       input logic zero, input logic [31:0] pc, input logic [31:0] imm,
                       input logic [31:0] rs1, input logic pt, input logic [31:0] ptgt);
    m_clear();
    i_Valid_M = 1; i_IsBranch_M = br; i_IsJump_M = jmp; i_BranchAdderBSel_M = sel;
    i_BranchType_M = ty; i_AluResZero_M = zero; i_PC_M = pc; i_Imm_M = imm; i_RS1_M = rs1;
    i_PredTaken_M = pt; i_PredTarget_M = ptgt;
  endtask

  // Trap redirect used to steer fetch to a chosen address without training the BTB.
  task automatic goto_pc(input logic [31:0] addr);
    i_Trap = 1; i_TrapVec = addr;
    tick();
    i_Trap = 0;
  endtask

  task automatic flag_case(input string nm, input logic [2:0] ty, input logic as, input logic bs,
                           input logic cy, input logic z, input logic n, input logic exp);
    m_set(1'b1, 1'b0, 1'b0, ty, z, 32'h700, 32'h10, 32'h0, 1'b0, 32'h704);
    i_AluASign_M = as; i_AluBSign_M = bs; i_AluCarry_M = cy; i_AluResNeg_M = n;
    exp_rd(nm, exp, exp);
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, %0d queued checks", q.size());
    $fatal(1);
  end

  initial begin
    i_Rst = 1; i_PcEn = 1; i_Trap = 0; i_Mret = 0; i_TrapVec = 0; i_Epc = 0;
    m_clear();
    repeat (2) @(posedge i_Clk);
    #1;
    exp_pc("in_reset", 32'h100);
    exp_pred("in_reset", 1'b0, 32'h104);
    exp_rd("in_reset", 1'b0, 1'b0);
    tick();
    i_Rst = 0;
    exp_pc("post_reset", 32'h100);
    for (int i = 1; i <= 5; i++) begin
      tick();
      exp_pc($sformatf("seq%0d", i), 32'h100 + 32'(4 * i));
    end
    i_PcEn = 0;
    tick();
    exp_pc("stall_hold", 32'h114);
    i_PcEn = 1;

    // first taken BEQ at 0x20 -> 0x80, not predicted
    goto_pc(32'h20);
    exp_pc("trap_to_20", 32'h20);
    exp_pred("empty_btb", 1'b0, 32'h24);
    m_set(1'b1, 1'b0, 1'b0, BEQ, 1'b1, 32'h20, 32'h60, 32'h0, 1'b0, 32'h24);
    exp_rd("beq_first", 1'b1, 1'b1);
    tick(); m_clear();
    exp_pc("beq_redirect", 32'h80);
    goto_pc(32'h20);
    exp_pred("beq_alloc", 1'b1, 32'h80);
    tick();
    exp_pc("follow_pred", 32'h80);

    // predicted taken, resolves not taken: counter 2 -> 1
    m_set(1'b1, 1'b0, 1'b0, BEQ, 1'b0, 32'h20, 32'h60, 32'h0, 1'b1, 32'h80);
    exp_rd("beq_nt", 1'b1, 1'b0);
    tick(); m_clear();
    exp_pc("nt_redirect", 32'h24);
    goto_pc(32'h20);
    exp_pred("nt_weak", 1'b0, 32'h80);
    tick();
    exp_pc("nt_sequential", 32'h24);

    // two correct not-taken (1 -> 0 -> 0), then taken (0 -> 1): still predicts not taken
    m_set(1'b1, 1'b0, 1'b0, BEQ, 1'b0, 32'h20, 32'h60, 32'h0, 1'b0, 32'h24);
    exp_rd("nt_ok", 1'b0, 1'b0);
    tick(); tick();
    m_set(1'b1, 1'b0, 1'b0, BEQ, 1'b1, 32'h20, 32'h60, 32'h0, 1'b0, 32'h24);
    tick(); m_clear();
    exp_pc("sat_redirect", 32'h80);
    goto_pc(32'h20);
    exp_pred("sat_low", 1'b0, 32'h80);

    // JALR at 0x50: learn 0x200, then actual 0x300 with 0x200 predicted
    m_set(1'b0, 1'b1, 1'b1, BNE, 1'b1, 32'h50, 32'h10, 32'h1F0, 1'b0, 32'h54);
    exp_rd("jalr_first", 1'b1, 1'b1);
    tick(); m_clear();
    exp_pc("jalr_first_pc", 32'h200);
    m_set(1'b0, 1'b1, 1'b1, BNE, 1'b1, 32'h50, 32'h10, 32'h2F0, 1'b1, 32'h200);
    exp_rd("jalr_tgt_mp", 1'b1, 1'b1);
    tick(); m_clear();
    exp_pc("jalr_redirect", 32'h300);
    goto_pc(32'h50);
    exp_pred("jalr_btb", 1'b1, 32'h300);
    m_set(1'b0, 1'b1, 1'b1, BNE, 1'b1, 32'h50, 32'h10, 32'h2F0, 1'b1, 32'h300);
    exp_rd("jalr_ok", 1'b0, 1'b1);
    tick(); m_clear();
    exp_pc("jalr_pred_follow", 32'h300);

    // trap while stalled with a simultaneous mispredict at 0x64; then mret
    i_PcEn = 0; i_Trap = 1; i_TrapVec = 32'h1000;
    m_set(1'b1, 1'b0, 1'b0, BEQ, 1'b1, 32'h64, 32'h40, 32'h0, 1'b0, 32'h68);
    exp_rd("trap_mp", 1'b1, 1'b1);
    tick(); i_Trap = 0; m_clear();
    exp_pc("trap_no_en", 32'h1000);
    i_Mret = 1; i_Epc = 32'h2000;
    exp_rd("mret", 1'b1, 1'b0);
    tick(); i_Mret = 0;
    exp_pc("mret_pc", 32'h2000);
    tick();
    exp_pc("stall_after_mret", 32'h2000);
    i_PcEn = 1; i_Trap = 1; i_TrapVec = 32'h64; i_Mret = 1;
    tick(); i_Trap = 0; i_Mret = 0;
    exp_pc("trap_over_mret", 32'h64);
    exp_pred("trap_no_train", 1'b0, 32'h68);

    // aliasing: 0x40 and 0x80 share index 0
    m_set(1'b1, 1'b0, 1'b0, BEQ, 1'b1, 32'h40, 32'hC0, 32'h0, 1'b0, 32'h44);
    exp_rd("alias_a", 1'b1, 1'b1);
    tick(); m_clear();
    exp_pc("alias_a_pc", 32'h100);
    m_set(1'b1, 1'b0, 1'b0, BEQ, 1'b1, 32'h80, 32'h180, 32'h0, 1'b0, 32'h84);
    tick(); m_clear();
    exp_pc("alias_b_pc", 32'h200);
    goto_pc(32'h40);
    exp_pred("alias_evicted", 1'b0, 32'h44);
    goto_pc(32'h80);
    exp_pred("alias_new", 1'b1, 32'h200);
    // same-cycle write to the looked-up index: lookup still shows the old counter
    m_set(1'b1, 1'b0, 1'b0, BEQ, 1'b0, 32'h80, 32'h180, 32'h0, 1'b1, 32'h200);
    exp_rd("alias_nt", 1'b1, 1'b0);
    tick(); m_clear();
    exp_pc("alias_nt_pc", 32'h84);
    goto_pc(32'h80);
    exp_pred("alias_weak", 1'b0, 32'h200);

    // non-control instruction predicted taken falls through; invalid M ignored
    m_set(1'b0, 1'b0, 1'b0, BEQ, 1'b0, 32'h300, 32'h0, 32'h0, 1'b1, 32'h400);
    exp_rd("nonbr_pred", 1'b1, 1'b0);
    tick(); m_clear();
    exp_pc("nonbr_fix", 32'h304);
    m_set(1'b1, 1'b0, 1'b0, BEQ, 1'b1, 32'h20, 32'h60, 32'h0, 1'b0, 32'h24);
    i_Valid_M = 0;
    exp_rd("invalid_m", 1'b0, 1'b0);
    tick();

    i_PcEn = 0;
    flag_case("bne_ne",   BNE,    1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    flag_case("bne_eq",   BNE,    1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    flag_case("beq_ne",   BEQ,    1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    flag_case("blt_sgn",  BLT,    1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    flag_case("blt_neg",  BLT,    1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    flag_case("blt_ovf",  BLT,    1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    flag_case("bge_neg",  BGE,    1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    flag_case("bge_sgn",  BGE,    1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    flag_case("bltu_bor", BLTU,   1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    flag_case("bltu_cy",  BLTU,   1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    flag_case("bgeu_cy",  BGEU,   1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    flag_case("bad_f3",   3'b010, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    m_clear();

    @(negedge i_Clk);
    for (int k = 0; k < 10 && q.size() > 0; k++) @(negedge i_Clk);
    #1;
    if (q.size() > 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: %0d checks left in queue, expected 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pc_predict.md
# pc_predict

Parametrised fetch program-counter unit that adds branch prediction to the PC register. Every cycle it registers the next fetch address. It predicts taken branches and jumps through a direct-mapped branch target buffer (BTB) with 2-bit saturating counters. It resolves the real outcome in the M stage, then either corrects the fetch path with a redirect or trains the BTB. It also takes trap and mret redirects from the CSR block. It sits at the head of the CPU pipeline, feeding the instruction memory address and the IF-stage prediction tags.

## Interface
Parameters:
- XLEN, 32, address/data width.
- RESET_VEC, 32'h0, value loaded into o_Pc on reset.
- BTB_ENTRIES, 16, BTB depth; power of two, ≥2. IDX_W = log2(BTB_ENTRIES).

Ports:
- i_Clk  in  1  clock; one clock domain.
- i_Rst  in  1  asynchronous, active-high reset.
- i_PcEn  in  1  fetch advance enable; low = stall.
- i_Trap  in  1  trap taken; redirect to i_TrapVec.
- i_TrapVec  in  XLEN  trap handler address.
- i_Mret  in  1  return from trap; redirect to i_Epc.
- i_Epc  in  XLEN  saved exception PC.
- i_Valid_M  in  1  M-stage instruction valid; not flushed.
- i_IsJump_M, i_IsBranch_M  in  1  M-stage control-flow type.
- i_BranchType_M  in  3  branch condition (funct3 encoding).
- i_AluASign_M, i_AluBSign_M, i_AluCarry_M, i_AluResZero_M, i_AluResNeg_M  in  1  ALU flags for condition evaluation.
- i_BranchAdderBSel_M  in  1  target base select: 1 = RS1 (JALR), 0 = PC.
- i_Imm_M, i_PC_M, i_RS1_M  in  XLEN  target operands.
- i_PredTaken_M  in  1  prediction carried down the pipe with this instruction.
- i_PredTarget_M  in  XLEN  predicted target carried down the pipe.
- o_Pc  out  XLEN  current fetch address; registered.
- o_PredTaken  out  1  prediction for o_Pc; combinational.
- o_PredTarget  out  XLEN  predicted target for o_Pc; combinational.
- o_TakeBranch  out  1  M-stage resolved outcome: taken.
- o_Redirect  out  1  mispredict, trap or mret; pipeline flush request.

## Operation
- Condition evaluation uses the existing BranchUnit instance, unchanged. Resolved target = i_Imm_M + (i_BranchAdderBSel_M ? i_RS1_M : i_PC_M). Additions wrap modulo 2^XLEN.
- BTB entry fields: valid, tag = PC[XLEN-1:IDX_W+2], target, 2-bit counter. Index = PC[IDX_W+1:2].
- Lookup on o_Pc:
  - hit = valid && tag match.
  - o_PredTaken = hit && counter[1].
  - o_PredTarget = hit ? target : o_Pc+4.
- Mispredict = i_Valid_M && (branch||jump) && (taken != i_PredTaken_M || (taken && target != i_PredTarget_M)).
- A non-branch M instruction with i_PredTaken_M=1 is also a mispredict. Its correction is i_PC_M+4.
- Next-PC priority: i_Rst > i_Trap > i_Mret > mispredict > prediction > o_Pc+4.
  - Mispredict correction = taken ? resolved target : i_PC_M+4.
- o_Redirect = i_Trap || i_Mret || mispredict.
- Enable gating:
  - i_Trap and i_Mret update o_Pc regardless of i_PcEn.
  - Mispredict correction, prediction and sequential advance update o_Pc only when i_PcEn=1.
- BTB training happens when i_PcEn && i_Valid_M && (branch||jump) && !i_Trap.
  - Hit: counter saturating +1 if taken, −1 if not taken. On taken, target is rewritten.
  - Miss and taken: allocate the entry with valid=1, tag, target, counter=2'b10. A conditional branch with the same index is overwritten.
  - Miss and not taken: no allocation.
  - Jumps always train as taken.
- Simultaneous lookup and write to the same index: lookup returns the pre-write contents.

## Timing
- Reset, asynchronous: o_Pc=RESET_VEC, all valid bits=0, all counters=2'b01. Targets and tags are not reset. Consequently o_PredTaken=0 and o_PredTarget=RESET_VEC+4.
- Reset deasserted mid-operation: the first edge after deassertion loads the next PC from the RESET_VEC lookup.
- Redirect latency: o_Pc holds the corrected address one clock after the cycle o_Redirect is high. The mispredict penalty is therefore the instructions in IF..E.
- A BTB write is visible to a lookup on the following cycle.
- o_TakeBranch and o_Redirect are combinational from the M inputs; there are no registered delays.

## Structure
- Package pc_pkg holds:
  - branch-type encodings (BEQ, BNE, BLT, BGE, BLTU, BGEU);
  - counter constants: SNT=0, WNT=1, WT=2, ST=3;
  - the BTB entry typedef;
  - default XLEN.
- Sub-module pc_btb holds BTB storage, lookup and the training update. It is parametrised by XLEN and BTB_ENTRIES.
- pc_predict keeps next-PC muxing, mispredict detection and the BranchUnit instance.

## Test plan
- Reset with RESET_VEC=32'h100 → o_Pc=32'h100, o_PredTaken=0. Five enabled cycles → o_Pc=32'h114.
- First encounter of taken BEQ at PC 32'h20 to 32'h80 (not predicted) → o_Redirect=1, o_Pc=32'h80 next cycle, entry allocated with counter=2. The next fetch of 32'h20 gives o_PredTaken=1 and o_PredTarget=32'h80.
- Predicted-taken branch at 32'h20 resolves not taken → o_Redirect=1, o_Pc=32'h24, counter 2→1. Next fetch of 32'h20 predicts not taken.
- JALR with predicted target 32'h200 and actual RS1+imm=32'h300 → mispredict, o_Pc=32'h300, BTB target updated to 32'h300.
- i_Trap=1 with i_PcEn=0 and a simultaneous mispredict → o_Pc=i_TrapVec next cycle, no BTB write. i_Mret then → o_Pc=i_Epc.
- Aliasing: PCs 32'h40 and 32'h40+4·BTB_ENTRIES, both taken → the second allocation evicts the first, and fetching the first address gives a tag miss with o_PredTaken=0.
